// File: rtl/sipo_rx_pkg.sv
// Shared state encoding, counter sizing and line constants for the serial receive controller.
package sipo_rx_pkg;

    localparam logic SIPO_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    // Width needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out shifter: shifts right, so the first bit in ends up in q[0] after WIDTH shifts.
module sipo_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == WIDTH - 1) begin : g_msb
                assign w_q_next[gi] = din;
            end else begin : g_inner
                assign w_q_next[gi] = r_q[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            r_q <= '0;
        end else if (shift_en) begin
            r_q <= w_q_next;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Serial frame receiver: start detect, mid-bit sampling, SIPO sequencing and valid/ready output holding.
// Optional even-parity bit after the data is enabled with `define SIPO_RX_PARITY_EN.
module sipo_rx_ctrl
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int BIT_DIV = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             ser_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] par_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             overrun_o,
    output logic             framing_err_o,
    output logic             parity_err_o
);

    localparam int CW = cnt_width(BIT_DIV);
    localparam int BW = cnt_width(WIDTH);
    localparam logic [CW-1:0] HALF_M1  = CW'(BIT_DIV / 2 - 1);
    localparam logic [CW-1:0] DIV_M1   = CW'(BIT_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    rx_state_t        r_state;
    logic [CW-1:0]    r_cnt;
    logic [BW-1:0]    r_bits;
    logic             r_shift_en;
    logic             r_shift_din;
    logic             r_done;
    logic             r_stop_ok;
    logic             w_par_bad;
    logic             w_good;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] r_par;
    logic             r_valid;
    logic             r_overrun;
    logic             r_ferr;

`ifdef SIPO_RX_PARITY_EN
    logic r_par_acc;
    logic r_par_bad;
    logic r_perr;
    assign w_par_bad    = r_par_bad;
    assign parity_err_o = r_perr;
`else
    assign w_par_bad    = 1'b0;
    assign parity_err_o = 1'b0;
`endif

    sipo_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk      (wb_clk_i),
        .srst     (wb_rst_i),
        .shift_en (r_shift_en),
        .din      (r_shift_din),
        .q        (w_q)
    );

    // Bit-timing counter restarts at each sample so spacing stays exactly BIT_DIV.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bits      <= '0;
            r_shift_en  <= 1'b0;
            r_shift_din <= 1'b0;
            r_done      <= 1'b0;
            r_stop_ok   <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            r_par_acc   <= 1'b0;
            r_par_bad   <= 1'b0;
`endif
        end else begin
            r_shift_en <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ser_i != SIPO_IDLE_LEVEL) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt   <= '0;
                        r_bits  <= '0;
                        r_state <= (ser_i == SIPO_IDLE_LEVEL) ? ST_IDLE : ST_DATA;
`ifdef SIPO_RX_PARITY_EN
                        r_par_acc <= 1'b0;
                        r_par_bad <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == DIV_M1) begin
                        r_cnt       <= '0;
                        r_shift_en  <= 1'b1;
                        r_shift_din <= ser_i;
                        r_bits      <= r_bits + 1'b1;
`ifdef SIPO_RX_PARITY_EN
                        r_par_acc   <= r_par_acc ^ ser_i;
                        if (r_bits == LAST_BIT) r_state <= ST_PARITY;
`else
                        if (r_bits == LAST_BIT) r_state <= ST_STOP;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef SIPO_RX_PARITY_EN
                ST_PARITY: begin
                    if (r_cnt == DIV_M1) begin
                        r_cnt     <= '0;
                        r_par_bad <= r_par_acc ^ ser_i;
                        r_state   <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (r_cnt == DIV_M1) begin
                        r_cnt     <= '0;
                        r_done    <= 1'b1;
                        r_stop_ok <= ser_i;
                        r_state   <= (ser_i == SIPO_IDLE_LEVEL) ? ST_IDLE : ST_WAIT_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (ser_i == SIPO_IDLE_LEVEL) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_good = r_done & r_stop_ok & ~w_par_bad;

    // Output holding register: a consumer handshake in the same cycle frees room for the new word.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_par     <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            r_perr    <= 1'b0;
`endif
        end else begin
            r_overrun <= 1'b0;
            r_ferr    <= r_done & ~r_stop_ok;
`ifdef SIPO_RX_PARITY_EN
            r_perr    <= r_done & r_par_bad;
`endif
            if (w_good) begin
                if (!r_valid || ready_i) begin
                    r_par   <= w_q;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign par_o         = r_par;
    assign valid_o       = r_valid;
    assign busy_o        = (r_state != ST_IDLE);
    assign overrun_o     = r_overrun;
    assign framing_err_o = r_ferr;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed bench for sipo_rx_ctrl: frames are driven bit-accurately and received words are scoreboarded.
module tb_sipo_rx_ctrl;

    localparam int W  = 4;
    localparam int BD = 4;
    localparam int H  = BD / 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         ser_i;
    logic         ready_i;
    logic [W-1:0] par_o;
    logic         valid_o;
    logic         busy_o;
    logic         overrun_o;
    logic         framing_err_o;
    logic         parity_err_o;

    int checks = 0;
    int errors = 0;
    int n_ov = 0;
    int n_fe = 0;
    int n_pe = 0;
    int base_ov, base_fe, base_pe;

    logic [W-1:0] exp_q[$];
    logic         v_before, v_at, ov_at, fe_at, pe_at;
    logic [W-1:0] par_at;
    logic [W-1:0] first_word;

`ifdef SIPO_RX_PARITY_EN
    bit par_flip = 1'b0;
`endif

    sipo_rx_ctrl #(
        .WIDTH   (W),
        .BIT_DIV (BD)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .ser_i         (ser_i),
        .ready_i       (ready_i),
        .par_o         (par_o),
        .valid_o       (valid_o),
        .busy_o        (busy_o),
        .overrun_o     (overrun_o),
        .framing_err_o (framing_err_o),
        .parity_err_o  (parity_err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (overrun_o)     n_ov++;
            if (framing_err_o) n_fe++;
            if (parity_err_o)  n_pe++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag, input logic [W-1:0] obs);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed %0h expected none (scoreboard empty)", tag, obs);
        end else begin
            check(tag, 32'(obs), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic mark();
        base_ov = n_ov;
        base_fe = n_fe;
        base_pe = n_pe;
    endtask

    // Start bit is set just before edge t; the task returns right after edge t+H+(W+1+P)*BD+1.
    task automatic send_frame(input logic [W-1:0] data, input logic stop_bit, input bit raise_ready);
        ser_i = 1'b0;
        repeat (BD) @(negedge clk);
        for (int k = 0; k < W; k++) begin
            ser_i = data[k];
            repeat (BD) @(negedge clk);
        end
`ifdef SIPO_RX_PARITY_EN
        ser_i = (^data) ^ par_flip;
        repeat (BD) @(negedge clk);
`endif
        ser_i = stop_bit;
        for (int i = 0; i < BD; i++) begin
            @(negedge clk);
            if (i == H) begin
                v_before = valid_o;
                if (raise_ready) ready_i = 1'b1;
            end
            if (i == H + 1) begin
                v_at   = valid_o;
                par_at = par_o;
                ov_at  = overrun_o;
                fe_at  = framing_err_o;
                pe_at  = parity_err_o;
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        ser_i   = 1'b1;
        ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hold_valid", valid_o, 0);
        check("rst_hold_busy", busy_o, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_par", par_o, 0);
        check("idle_valid", valid_o, 0);
        check("idle_busy", busy_o, 0);
        check("idle_overrun", overrun_o, 0);
        check("idle_framing", framing_err_o, 0);
        check("idle_parity", parity_err_o, 0);
        $display("step reset: par=%0h valid=%0b busy=%0b", par_o, valid_o, busy_o);

        // Frame 0,1,0,1 with consumer ready: word appears exactly one edge after the stop sample.
        ready_i = 1'b1;
        mark();
        exp_q.push_back(4'hA);
        send_frame(4'hA, 1'b1, 1'b0);
        check("a_valid_early", v_before, 0);
        check("a_valid", v_at, 1);
        check_pop("a_par", par_at);
        @(negedge clk);
        check("a_valid_drop", valid_o, 0);
        check("a_busy", busy_o, 0);
        check("a_no_err", 32'(n_ov + n_fe + n_pe - base_ov - base_fe - base_pe), 0);
        $display("step frame A: par=%0h valid_after=%0b", par_at, valid_o);

        // Overrun: second word dropped while the first is still held.
        ready_i = 1'b0;
        mark();
        exp_q.push_back(4'h3);
        send_frame(4'h3, 1'b1, 1'b0);
        check("ov_first_valid", v_at, 1);
        check_pop("ov_first_par", par_at);
        send_frame(4'h5, 1'b1, 1'b0);
        check("ov_pulse", ov_at, 1);
        check("ov_par_kept", par_o, 4'h3);
        check("ov_valid_kept", valid_o, 1);
        ready_i = 1'b1;
        @(negedge clk);
        check("ov_consume", valid_o, 0);
        repeat (5) @(negedge clk);
        check("ov_once", 32'(n_ov - base_ov), 1);
        $display("step overrun: par=%0h overruns=%0d", par_o, n_ov - base_ov);

        // New frame lands in the same cycle the consumer takes the held word: no overrun.
        ready_i = 1'b0;
        mark();
        exp_q.push_back(4'h6);
        send_frame(4'h6, 1'b1, 1'b0);
        check_pop("swap_first_par", par_at);
        exp_q.push_back(4'h9);
        send_frame(4'h9, 1'b1, 1'b1);
        check("swap_no_overrun", ov_at, 0);
        check("swap_valid", v_at, 1);
        check_pop("swap_par", par_at);
        @(negedge clk);
        check("swap_drop", valid_o, 0);
        $display("step swap: par=%0h overruns=%0d", par_at, n_ov - base_ov);

        // Back-to-back frames.
        ready_i = 1'b1;
        exp_q.push_back(4'h1);
        exp_q.push_back(4'hE);
        send_frame(4'h1, 1'b1, 1'b0);
        first_word = par_at;
        check("b2b_first_valid", v_at, 1);
        send_frame(4'hE, 1'b1, 1'b0);
        check_pop("b2b_first_par", first_word);
        check("b2b_second_valid", v_at, 1);
        check_pop("b2b_second_par", par_at);
        $display("step back-to-back: first=%0h second=%0h", first_word, par_at);

        // Single-cycle glitch rejected by the start re-check.
        mark();
        @(negedge clk);
        ser_i = 1'b0;
        @(negedge clk);
        check("glitch_busy", busy_o, 1);
        ser_i = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk);
        check("glitch_idle", busy_o, 0);
        repeat (30) @(negedge clk);
        check("glitch_no_valid", valid_o, 0);
        check("glitch_no_err", 32'(n_ov + n_fe + n_pe - base_ov - base_fe - base_pe), 0);
        $display("step glitch: busy=%0b valid=%0b", busy_o, valid_o);

        // Stop bit low, line held low: framing error, wait for idle.
        mark();
        send_frame(4'hC, 1'b0, 1'b0);
        check("fe_pulse", fe_at, 1);
        check("fe_no_valid", v_at, 0);
        repeat (10) @(negedge clk);
        check("fe_busy_low", busy_o, 1);
        check("fe_valid", valid_o, 0);
        check("fe_once", 32'(n_fe - base_fe), 1);
        ser_i = 1'b1;
        @(negedge clk);
        check("fe_release", busy_o, 0);
        $display("step framing: errors=%0d busy=%0b", n_fe - base_fe, busy_o);

        // Reset mid-frame discards partial bits and the pending word.
        ready_i = 1'b0;
        exp_q.push_back(4'h2);
        send_frame(4'h2, 1'b1, 1'b0);
        check_pop("rm_pending_par", par_at);
        ser_i = 1'b0;
        repeat (BD) @(negedge clk);
        ser_i = 1'b1;
        repeat (BD + 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rm_busy", busy_o, 0);
        check("rm_valid", valid_o, 0);
        check("rm_par", par_o, 0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("rm_quiet_valid", valid_o, 0);
        check("rm_quiet_busy", busy_o, 0);
        ready_i = 1'b1;
        exp_q.push_back(4'hB);
        send_frame(4'hB, 1'b1, 1'b0);
        check_pop("rm_recover_par", par_at);
        $display("step reset-mid: recovered par=%0h", par_at);

`ifdef SIPO_RX_PARITY_EN
        mark();
        par_flip = 1'b1;
        send_frame(4'h7, 1'b1, 1'b0);
        check("pe_pulse", pe_at, 1);
        check("pe_no_valid", v_at, 0);
        check("pe_once", 32'(n_pe - base_pe), 1);
        par_flip = 1'b0;
        exp_q.push_back(4'h7);
        send_frame(4'h7, 1'b1, 1'b0);
        check("pe_good_flag", pe_at, 0);
        check("pe_good_valid", v_at, 1);
        check_pop("pe_good_par", par_at);
        $display("step parity: par=%0h", par_at);
`else
        check("no_parity_pulses", 32'(n_pe), 0);
`endif

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
